// File: rtl/demux4_dispatcher.sv
// Registered 1-to-4 word dispatcher with per-channel holding registers, valid/ready
// handshakes and a fixed/round-robin scheduler. Define DEMUX_DISPATCH_CNT_EN for delivery counters.

module demux4_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic             o_valid,
`ifdef DEMUX_DISPATCH_CNT_EN
  output logic [7:0]       o_cnt,
`endif
  output logic [WIDTH-1:0] o_data
);
  logic             r_vld;
  logic [WIDTH-1:0] r_data;
  logic             w_deliver;

  assign w_deliver = r_vld && i_ready;

  // Data is zeroed whenever the slot empties so idle channels read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (i_flush) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
    end else if (w_deliver) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end
  end

`ifdef DEMUX_DISPATCH_CNT_EN
  logic [7:0] r_cnt;

  // Deliveries during a flush cycle still count; flush never clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (w_deliver) r_cnt <= r_cnt + 8'd1;
  end

  assign o_cnt = r_cnt;
`endif

  assign o_valid = r_vld;
  assign o_data  = r_data;
endmodule

module demux4_dispatcher #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rr_mode,
  input  logic             flush,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [3:0]       out_valid,
`ifdef DEMUX_DISPATCH_CNT_EN
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3,
  output logic [7:0]       cnt4,
`endif
  input  logic [3:0]       out_ready
);
  localparam int NUM_LANES = 4;

  logic [1:0]                            r_rr_ptr;
  logic [NUM_LANES-1:0]                  w_vld;
  logic [NUM_LANES-1:0]                  w_free;
  logic [NUM_LANES-1:0]                  w_load;
  logic [NUM_LANES-1:0][WIDTH-1:0]       w_data;
  logic [1:0]                            w_tgt;
  logic                                  w_tgt_ok;
  logic                                  w_accept;
`ifdef DEMUX_DISPATCH_CNT_EN
  logic [NUM_LANES-1:0][7:0]             w_cnt;
`endif

  assign w_free = ~w_vld | out_ready;

  // Round-robin search runs high-to-low offset so the nearest free slot after rr_ptr wins.
  always_comb begin
    w_tgt    = sel;
    w_tgt_ok = 1'b1;
    if (rr_mode) begin
      w_tgt    = r_rr_ptr;
      w_tgt_ok = 1'b0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (w_free[r_rr_ptr + 2'(i)]) begin
          w_tgt    = r_rr_ptr + 2'(i);
          w_tgt_ok = 1'b1;
        end
      end
    end
  end

  assign in_ready = !flush && w_tgt_ok && w_free[w_tgt];
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_load        = '0;
    w_load[w_tgt] = w_accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_rr_ptr <= 2'd0;
    else if (flush)                r_rr_ptr <= 2'd0;
    else if (w_accept && rr_mode)  r_rr_ptr <= w_tgt + 2'd1;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux4_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[g]),
      .i_data  (in),
      .i_ready (out_ready[g]),
      .i_flush (flush),
      .o_valid (w_vld[g]),
`ifdef DEMUX_DISPATCH_CNT_EN
      .o_cnt   (w_cnt[g]),
`endif
      .o_data  (w_data[g])
    );
  end

  assign out_valid = w_vld;
  assign out1      = w_data[0];
  assign out2      = w_data[1];
  assign out3      = w_data[2];
  assign out4      = w_data[3];
`ifdef DEMUX_DISPATCH_CNT_EN
  assign cnt1      = w_cnt[0];
  assign cnt2      = w_cnt[1];
  assign cnt3      = w_cnt[2];
  assign cnt4      = w_cnt[3];
`endif
endmodule

// File: tb/tb_demux4_dispatcher.sv
// Scoreboard bench for demux4_dispatcher: per-channel expected-word queues fed at accept,
// drained by an independent monitor at each delivery handshake.

module tb_demux4_dispatcher;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = '0;
  logic [1:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        rr_mode = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  out_ready = '0;
  wire         in_ready;
  wire  [15:0] out1, out2, out3, out4;
  wire  [3:0]  out_valid;
`ifdef DEMUX_DISPATCH_CNT_EN
  wire  [7:0]  cnt1, cnt2, cnt3, cnt4;
  wire  [7:0]  c [4];
  assign c[0] = cnt1; assign c[1] = cnt2; assign c[2] = cnt3; assign c[3] = cnt4;
`endif
  wire  [15:0] o [4];
  assign o[0] = out1; assign o[1] = out2; assign o[2] = out3; assign o[3] = out4;

  demux4_dispatcher #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .rr_mode(rr_mode), .flush(flush),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out_valid(out_valid),
`ifdef DEMUX_DISPATCH_CNT_EN
    .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .cnt4(cnt4),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q [4][$];
  int          ptr_m;
  int          cnt_m [4];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable between edges; a handshake seen here completes on the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("valid%0d", n), out_valid[n], exp_q[n].size() != 0);
`ifdef DEMUX_DISPATCH_CNT_EN
        chk($sformatf("cnt%0d", n + 1), c[n], cnt_m[n]);
`endif
        if (out_valid[n] && out_ready[n]) begin
          if (exp_q[n].size() != 0) chk($sformatf("data%0d", n), o[n], exp_q[n].pop_front());
          cnt_m[n] = (cnt_m[n] + 1) % 256;
        end else if (!out_valid[n]) begin
          chk($sformatf("idle_zero%0d", n), o[n], 0);
        end
      end
    end
  end

  // One cycle of stimulus; the reference decides acceptance from queue occupancy after the monitor pop.
  task automatic step(input bit v, input logic [15:0] d, input logic [1:0] s,
                      input bit rr, input bit fl, input logic [3:0] ordy);
    int  tgt;
    bit  found;
    bit  exp_rdy;
    @(negedge clk);
    in_valid = v; in = d; sel = s; rr_mode = rr; flush = fl; out_ready = ordy;
    #2;
    tgt = -1;
    if (!rr) tgt = int'(s);
    else begin
      found = 1'b0;
      for (int i = 0; i < 4; i++)
        if (!found && exp_q[(ptr_m + i) % 4].size() == 0) begin
          tgt = (ptr_m + i) % 4;
          found = 1'b1;
        end
    end
    exp_rdy = !fl && tgt >= 0 && exp_q[tgt].size() == 0;
    chk("in_ready", in_ready, exp_rdy);
    if (fl) begin
      for (int n = 0; n < 4; n++) exp_q[n].delete();
      ptr_m = 0;
    end else if (v && exp_rdy) begin
      exp_q[tgt].push_back(d);
      if (rr) ptr_m = (tgt + 1) % 4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      exp_q[n].delete();
      cnt_m[n] = 0;
    end
    ptr_m = 0;
    in_valid = 1'b0; flush = 1'b0; out_ready = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_outs", {out1, out2}, 32'h0);
    chk("rst_outs34", {out3, out4}, 32'h0);
`ifdef DEMUX_DISPATCH_CNT_EN
    chk("rst_cnts", {cnt1, cnt2, cnt3, cnt4}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ptr_m = 0;
    for (int n = 0; n < 4; n++) cnt_m[n] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state and single fixed-mode word to channel 3
    step(0, 16'h0, 2'd0, 0, 0, 4'hF);
    chk("reset_ov", out_valid, 4'b0000);
    step(1, 16'hA5A5, 2'd2, 0, 0, 4'hF);
    step(0, 16'h0, 2'd0, 0, 0, 4'hF);
    chk("t1_ov", out_valid, 4'b0100);
    chk("t1_out3", out3, 16'hA5A5);
    step(0, 16'h0, 2'd0, 0, 0, 4'hF);
    chk("t1_ov_after", out_valid, 4'b0000);

    // back-pressure on channel 1 in fixed mode
    step(1, 16'h1111, 2'd0, 0, 0, 4'h0);
    step(1, 16'h2222, 2'd0, 0, 0, 4'h0);
    step(1, 16'h2222, 2'd0, 0, 0, 4'h0);
    step(1, 16'h2222, 2'd0, 0, 0, 4'b0001);
    step(0, 16'h0, 2'd0, 0, 0, 4'hF);
    step(0, 16'h0, 2'd0, 0, 0, 4'hF);

    // round-robin sweep with wrap
    for (int k = 1; k <= 8; k++) step(1, 16'(k), 2'd0, 1, 0, 4'hF);
    step(0, 16'h0, 2'd0, 1, 0, 4'hF);
    step(0, 16'h0, 2'd0, 1, 0, 4'hF);

    // stalled channel 2 skipped by round-robin
    step(1, 16'hBEEF, 2'd1, 0, 0, 4'b1101);
    for (int k = 1; k <= 4; k++) step(1, 16'h100 + 16'(k), 2'd0, 1, 0, 4'b1101);
    step(0, 16'h0, 2'd0, 1, 0, 4'hF);
    step(0, 16'h0, 2'd0, 1, 0, 4'hF);

    // fill all channels (leaving rr_ptr at 3), then flush
    step(1, 16'hC000, 2'd0, 0, 0, 4'h0);
    step(1, 16'hC001, 2'd1, 0, 0, 4'h0);
    step(1, 16'hC003, 2'd3, 0, 0, 4'h0);
    step(1, 16'hC002, 2'd0, 1, 0, 4'h0);
    step(1, 16'hDEAD, 2'd0, 1, 1, 4'h0);
    step(0, 16'h0, 2'd0, 1, 0, 4'h0);
    chk("flush_ov", out_valid, 4'b0000);
    chk("flush_outs", {out1, out2, out3, out4}, 32'h0);
    step(1, 16'hF00D, 2'd0, 1, 0, 4'hF);
    step(0, 16'h0, 2'd0, 1, 0, 4'hF);
    chk("flush_ptr0", out_valid, 4'b0001);
    step(0, 16'h0, 2'd0, 1, 0, 4'hF);

    // randomized traffic
    for (int k = 0; k < 3000; k++)
      step($urandom % 4 != 0, 16'($urandom), 2'($urandom), 1'($urandom), $urandom % 32 == 0,
           4'($urandom));

    // mid-stream reset with words held
    step(1, 16'h7777, 2'd1, 0, 0, 4'h0);
    step(1, 16'h8888, 2'd0, 1, 0, 4'h0);
    do_reset();

    // 257 deliveries on channel 4
    for (int k = 0; k < 257; k++) step(1, 16'(k), 2'd3, 0, 0, 4'hF);
    step(0, 16'h0, 2'd0, 0, 0, 4'hF);
    step(0, 16'h0, 2'd0, 0, 0, 4'hF);
`ifdef DEMUX_DISPATCH_CNT_EN
    chk("cnt4_wrap", cnt4, 8'd1);
    chk("cnt_others", {cnt1, cnt2, cnt3}, 24'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux4_dispatcher.md
# demux4_dispatcher

Registered 1-to-4 dispatcher that sequences a 16-bit word stream onto four downstream channels, with valid/ready handshaking on every side. It sits in front of the 16-bit four-way demux datapath and adds what that path lacks: per-channel holding registers, back-pressure, and a selectable round-robin scheduler that shares one producer between four consumers. Idle outputs read zero, as in the combinational demux.

## Interface
Parameters:
- `WIDTH`, default 16, data word width.

Ports (clock and reset first):
- `clk`  input  1  system clock. Everything is sampled on the rising edge.
- `rst_n`  input  1  reset. Asynchronous, active-low.
- `in`  input  WIDTH  input data word.
- `sel`  input  2  destination channel (0..3) in fixed mode. Ignored in round-robin mode.
- `in_valid`  input  1  producer has a word.
- `in_ready`  output  1  dispatcher accepts the word this cycle.
- `rr_mode`  input  1  selects the mode: 1 = round-robin, 0 = fixed (`sel`).
- `flush`  input  1  synchronous clear of all holding registers.
- `out1`..`out4`  output  WIDTH each  channel data. Zero whenever that channel's valid is 0.
- `out_valid`  output  4  bit n-1 is the valid for `out`n.
- `out_ready`  input  4  bit n-1 is the consumer-ready for `out`n.
- `cnt1`..`cnt4`  output  8 each  delivered-word counters. Present only with `DEMUX_DISPATCH_CNT_EN`.

## Operation
- Each channel has a one-entry holding register with a valid bit.
- A slot is free in a cycle when `!out_valid[n] || out_ready[n]`.
- Target channel selection:
  - Fixed mode: target = `sel`.
  - Round-robin mode: target = first free slot found searching from `rr_ptr` upward, modulo 4.
  - If no slot is free, there is no target.
- `in_ready` = `!flush` and a target exists and that target slot is free. `in_ready` is combinational from `out_valid`, `out_ready`, `sel`, `rr_mode`, `flush` and `rr_ptr`. It never depends on `in_valid`.
- Accept occurs when `in_valid && in_ready`. On accept, the target register loads `in` and its valid is set.
- Delivery on channel n occurs when `out_valid[n] && out_ready[n]`.
  - Delivery without a simultaneous load to the same channel clears the valid and zeroes the data.
  - Delivery plus load in the same cycle: the new word replaces the old and valid stays 1.
- `rr_ptr` (2-bit):
  - On an accept in round-robin mode to channel k, `rr_ptr` becomes (k+1) mod 4, wrapping 3 to 0.
  - Unchanged otherwise, including on every fixed-mode accept.
- `flush`:
  - Next edge: all valids 0, all data 0, `rr_ptr` 0.
  - Any delivery in that same cycle still counts.
  - No input is accepted during a flush cycle.
- Changing `rr_mode` takes effect in the same cycle. Held words are not disturbed.
- Words are never reordered within a channel and never duplicated.

## Timing
- Reset values: `out1`..`out4` = 0, `out_valid` = 4'b0000, `rr_ptr` = 0, counters = 0.
  - `in_ready` follows from these, so it reads 1 after reset unless `flush` is high.
- Reset asserted mid-operation discards held words immediately, asynchronously.
- Latency is 1 cycle: a word accepted at edge t is visible on its channel after edge t.
- Throughput is 1 word/cycle per channel while the consumer holds `out_ready` high.
- A stalled channel blocks fixed-mode input aimed at it only. Round-robin mode skips it.
- Outputs are registered. The only combinational path is to `in_ready`.

## Configuration
- `DEMUX_DISPATCH_CNT_EN` defined:
  - Adds `cnt1`..`cnt4`. Each 8-bit counter increments on its channel's delivery handshake and wraps 255 to 0.
  - Counters are reset only by `rst_n`, not by `flush`.
- Undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset, then fixed mode, `sel`=2, `in`=16'hA5A5, one cycle of `in_valid` with `out_ready`=4'b1111 → `out3`=16'hA5A5 and `out_valid`=4'b0100 for exactly one cycle. `out1`, `out2` and `out4` stay 0.
- Fixed mode, `out_ready`=0, two words to `sel`=0 → first accepted. `in_ready`=0 on the second until `out_ready[0]` rises, then the second is accepted in that same cycle.
- Round-robin mode, `out_ready`=4'b1111, 8 consecutive words 1..8 → words 1..8 land on channels 1,2,3,4,1,2,3,4. `rr_ptr` wraps 3 to 0.
- Round-robin mode, `out_ready`=4'b1101 with channel 2 pre-filled → channel 2 skipped. Sequence goes 1,3,4,1. `in_ready` stays 1.
- All four channels full, `out_ready`=0, `flush`=1 with `in_valid`=1 → `in_ready`=0. Next cycle `out_valid`=0, all outs 0, `rr_ptr`=0.
- With `DEMUX_DISPATCH_CNT_EN`: 257 deliveries on channel 4 → `cnt4`=1, others 0. Assert `rst_n` low mid-stream → all counters and outputs 0 immediately.
